result_deskew_drain: RTL and testbench

- Output-side counterpart of the activation skew feeder: captures skewed per-column partial sums leaving the bottom of the systolic array and realigns them into whole result rows.
- Issues one accumulator write per row, either overwrite or accumulate, then signals completion to the controller.
- Sits between the systolic array bottom edge and the Accumulator (depth A_rows).

---
 rtl/result_deskew_drain_pkg.sv | 21 ++
 rtl/result_deskew_drain_delay_line.sv | 39 +++
 rtl/result_deskew_drain.sv | 145 ++++++++++++++
 tb/tb_result_deskew_drain.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_deskew_drain_pkg.sv
// result_deskew_drain_pkg
// Shared configuration for the result deskew/drain block. It holds the default
// array geometry, the partial-sum and result-row types, and the drain FSM states.
// Ports: none (package only).
package result_deskew_drain_pkg;

  localparam int sys_cols          = 50;
  localparam int Accumulator_depth = 50;
  localparam int P_BITWIDTH        = 24;
  localparam int ROW_W             = $clog2(Accumulator_depth);

  typedef logic [P_BITWIDTH-1:0] psum_t;
  typedef psum_t psum_row_t [sys_cols];

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } drain_state_t;

endpackage

// File: rtl/result_deskew_drain_delay_line.sv
// deskew_delay_line
// A fixed-length shift register that delays one column's {valid, psum} bundle
// by DEPTH clock cycles. DEPTH = 0 degenerates to a plain wire. Reset clears
// every stage, so no stale valid bits can leak out after a reset.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset
//   d     - bundle entering the line
//   q     - bundle leaving the line, DEPTH cycles later
module deskew_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign q = d;
    end else begin : g_regs
      logic [WIDTH-1:0] stages [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
        end else begin
          stages[0] <= d;
          for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
      end

      assign q = stages[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/result_deskew_drain.sv
// result_deskew_drain
// Captures the skewed per-column partial sums leaving the bottom of the
// systolic array and realigns them into whole result rows. Each aligned row
// becomes one accumulator write (overwrite or accumulate). When the expected
// number of rows has been written, done pulses for one cycle.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   start             - one-cycle pulse that arms a pass (only honoured in IDLE)
//   num_rows          - rows expected this pass (0 or > A_ROWS means A_ROWS)
//   acc_mode          - 1 = accumulate, 0 = overwrite (sampled on start)
//   in_valid, in_psum - per-column valid and partial sum from the array bottom
//   acc_wr_*          - registered accumulator write port
//   busy              - high while collecting rows
//   done              - one-cycle pulse after the last row is written
//   err_skew          - sticky: column valids disagreed after deskew
//   err_overflow      - sticky: a row arrived after the pass was full
module result_deskew_drain
  import result_deskew_drain_pkg::*;
#(
  parameter  int SYS_COLS   = sys_cols,
  parameter  int A_ROWS     = Accumulator_depth,
  parameter  int P_BITWIDTH = result_deskew_drain_pkg::P_BITWIDTH,
  localparam int ROW_W      = $clog2(A_ROWS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [ROW_W:0]                 num_rows,
  input  logic                           acc_mode,
  input  logic [SYS_COLS-1:0]            in_valid,
  input  logic [SYS_COLS*P_BITWIDTH-1:0] in_psum,
  output logic                           acc_wr_en,
  output logic [ROW_W-1:0]               acc_wr_addr,
  output logic                           acc_wr_accum,
  output logic [SYS_COLS*P_BITWIDTH-1:0] acc_wr_data,
  output logic                           busy,
  output logic                           done,
  output logic                           err_skew,
  output logic                           err_overflow
);

  localparam int             W        = P_BITWIDTH + 1;
  localparam logic [ROW_W:0] MAX_ROWS = (ROW_W + 1)'(A_ROWS);

  drain_state_t state, next_state;

  logic [SYS_COLS-1:0]            dly_valid;
  logic [SYS_COLS*P_BITWIDTH-1:0] dly_psum;
  logic [ROW_W:0]                 row_cnt;
  logic [ROW_W:0]                 num_rows_q;
  logic [ROW_W:0]                 num_rows_clamped;
  logic                           acc_mode_q;
  logic                           armed;
  logic                           row_full;
  logic                           row_partial;
  logic                           accept;

  // Column j enters the array bottom j cycles after column 0, so it is held
  // back SYS_COLS-1-j cycles; all columns of a row then line up together.
  generate
    for (genvar j = 0; j < SYS_COLS; j++) begin : g_col
      logic [W-1:0] q;

      deskew_delay_line #(
        .DEPTH(SYS_COLS - 1 - j),
        .WIDTH(W)
      ) u_delay (
        .clk  (clk),
        .rst_n(rst_n),
        .d    ({in_valid[j], in_psum[j*P_BITWIDTH +: P_BITWIDTH]}),
        .q    (q)
      );

      assign dly_valid[j]                          = q[W-1];
      assign dly_psum[j*P_BITWIDTH +: P_BITWIDTH] = q[P_BITWIDTH-1:0];
    end
  endgenerate

  // A row is only trusted when every column agrees it is valid. A partial set
  // means the upstream skew was broken, so the slice is discarded.
  assign row_full    = &dly_valid;
  assign row_partial = (|dly_valid) && !row_full;
  assign accept      = (state == COLLECT) && row_full && (row_cnt < num_rows_q);

  assign num_rows_clamped = ((num_rows == '0) || (num_rows > MAX_ROWS)) ? MAX_ROWS : num_rows;

  assign busy = (state == COLLECT);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // The pass ends once the write of the final row is on the output port, so
  // done lands in the cycle right after that write.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = COLLECT;
      COLLECT: if (acc_wr_en && (row_cnt == num_rows_q)) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Write port, row counter, pass configuration and sticky error flags.
  // Errors are only reported after some pass has armed the block, so stray
  // traffic seen out of reset is silently dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_wr_en    <= 1'b0;
      acc_wr_addr  <= '0;
      acc_wr_accum <= 1'b0;
      acc_wr_data  <= '0;
      row_cnt      <= '0;
      num_rows_q   <= '0;
      acc_mode_q   <= 1'b0;
      armed        <= 1'b0;
      err_skew     <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      acc_wr_en <= accept;
      if (accept) begin
        acc_wr_addr  <= row_cnt[ROW_W-1:0];
        acc_wr_accum <= acc_mode_q;
        acc_wr_data  <= dly_psum;
        row_cnt      <= row_cnt + 1'b1;
      end
      if ((state == IDLE) && start) begin
        num_rows_q   <= num_rows_clamped;
        acc_mode_q   <= acc_mode;
        row_cnt      <= '0;
        armed        <= 1'b1;
        err_skew     <= 1'b0;
        err_overflow <= 1'b0;
      end else begin
        if (armed && row_partial)          err_skew     <= 1'b1;
        if (armed && row_full && !accept)  err_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_result_deskew_drain.sv
// tb_result_deskew_drain
// Self-checking bench for result_deskew_drain with a 4x4 geometry. Writes are
// checked against a scoreboard of expected {addr, accum, data, cycle} entries;
// whole passes come from a vector table, corner cases from hand sequences.
module tb_result_deskew_drain;

  localparam int SC = 4;
  localparam int AR = 4;
  localparam int PW = 24;
  localparam int RW = $clog2(AR);

  typedef struct {
    logic [RW-1:0]      addr;
    logic               accum;
    logic [SC*PW-1:0]   data;
    int                 cyc;
  } wr_t;

  typedef struct {
    logic [RW:0] nr;
    logic        mode;
    int          sent;
    int          exp_wr;
    logic        exp_ovf;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [RW:0]        num_rows;
  logic               acc_mode;
  logic [SC-1:0]      in_valid;
  logic [SC*PW-1:0]   in_psum;
  logic               acc_wr_en;
  logic [RW-1:0]      acc_wr_addr;
  logic               acc_wr_accum;
  logic [SC*PW-1:0]   acc_wr_data;
  logic               busy;
  logic               done;
  logic               err_skew;
  logic               err_overflow;

  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  wr_cnt = 0;
  int  done_cnt = 0;
  int  last_wr_cyc = 0;
  int  done_cyc = 0;
  int  dummy_t;
  wr_t sb[$];
  vec_t vecs[6];

  result_deskew_drain #(
    .SYS_COLS  (SC),
    .A_ROWS    (AR),
    .P_BITWIDTH(PW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_rows    (num_rows),
    .acc_mode    (acc_mode),
    .in_valid    (in_valid),
    .in_psum     (in_psum),
    .acc_wr_en   (acc_wr_en),
    .acc_wr_addr (acc_wr_addr),
    .acc_wr_accum(acc_wr_accum),
    .acc_wr_data (acc_wr_data),
    .busy        (busy),
    .done        (done),
    .err_skew    (err_skew),
    .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        checkOutput("busy_low_in_done", busy, 0);
      end
      if (acc_wr_en) begin
        wr_t e;
        wr_cnt++;
        last_wr_cyc = cyc;
        if (sb.size() == 0) begin
          checkOutput("unexpected_write", 1, 0);
        end else begin
          e = sb.pop_front();
          checkOutput("wr_addr", acc_wr_addr, e.addr);
          checkOutput("wr_accum", acc_wr_accum, e.accum);
          checkOutput("wr_data", acc_wr_data, e.data);
          checkOutput("wr_cycle", cyc, e.cyc);
        end
      end
    end
  end

  function automatic logic [PW-1:0] pval(input int tag, input int r, input int j);
    return PW'((tag << 16) | (r << 8) | (j + 1));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setCol(input int j, input int r, input int tag);
    in_valid[j] = 1'b1;
    in_psum[j*PW +: PW] = pval(tag, r, j);
  endtask

  task automatic pulseStart(input logic [RW:0] nr, input logic mode);
    start = 1'b1;
    num_rows = nr;
    acc_mode = mode;
    step();
    start = 1'b0;
  endtask

  task automatic pushExpected(input int n, input logic mode, input int tag, input int t0);
    wr_t e;
    for (int r = 0; r < n; r++) begin
      e.addr = RW'(r);
      e.accum = mode;
      for (int j = 0; j < SC; j++) e.data[j*PW +: PW] = pval(tag, r, j);
      e.cyc = t0 + r + SC;
      sb.push_back(e);
    end
  endtask

  // Drives n rows with the array's natural skew: column j of row r in cycle t0+r+j.
  task automatic applyStimulus(input int n, input int tag, output int t0);
    t0 = cyc;
    for (int c = 0; c < n + SC - 1; c++) begin
      in_valid = '0;
      in_psum = '0;
      for (int j = 0; j < SC; j++)
        if (c - j >= 0 && c - j < n) setCol(j, c - j, tag);
      step();
    end
    in_valid = '0;
    in_psum = '0;
  endtask

  task automatic waitDone(input int prev);
    int waited = 0;
    while (done_cnt == prev && waited < 60) begin
      step();
      waited++;
    end
    checkOutput("done_seen", done_cnt > prev, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int t0;
    int wr0;
    int dn0;

    vecs[0] = '{nr: 3'd1, mode: 1'b0, sent: 1, exp_wr: 1, exp_ovf: 1'b0};
    vecs[1] = '{nr: 3'd4, mode: 1'b1, sent: 4, exp_wr: 4, exp_ovf: 1'b0};
    vecs[2] = '{nr: 3'd2, mode: 1'b0, sent: 5, exp_wr: 2, exp_ovf: 1'b1};
    vecs[3] = '{nr: 3'd0, mode: 1'b1, sent: 4, exp_wr: 4, exp_ovf: 1'b0};
    vecs[4] = '{nr: 3'd7, mode: 1'b0, sent: 5, exp_wr: 4, exp_ovf: 1'b1};
    vecs[5] = '{nr: 3'd3, mode: 1'b1, sent: 3, exp_wr: 3, exp_ovf: 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    num_rows = '0;
    acc_mode = 1'b0;
    in_valid = '0;
    in_psum = '0;
    step();
    step();
    checkOutput("reset_outputs",
                {acc_wr_en, acc_wr_addr, acc_wr_accum, acc_wr_data, busy, done, err_skew, err_overflow}, 0);
    rst_n = 1'b1;
    step();

    // Table-driven passes.
    for (int v = 0; v < 6; v++) begin
      wr0 = wr_cnt;
      dn0 = done_cnt;
      pulseStart(vecs[v].nr, vecs[v].mode);
      checkOutput("busy_in_collect", busy, 1);
      pushExpected(vecs[v].exp_wr, vecs[v].mode, v, cyc);
      applyStimulus(vecs[v].sent, v, t0);
      waitDone(dn0);
      repeat (3) step();
      checkOutput("pass_writes", wr_cnt - wr0, vecs[v].exp_wr);
      checkOutput("pass_done_count", done_cnt - dn0, 1);
      checkOutput("done_after_last_write", done_cyc, last_wr_cyc + 1);
      checkOutput("pass_err_skew", err_skew, 0);
      checkOutput("pass_err_overflow", err_overflow, vecs[v].exp_ovf);
      checkOutput("pass_busy_idle", busy, 0);
      checkOutput("pass_sb_empty", sb.size(), 0);
      sb.delete();
    end

    // Skew fault: column 2 of row 0 arrives one cycle late.
    wr0 = wr_cnt;
    dn0 = done_cnt;
    pulseStart(3'd1, 1'b0);
    setCol(0, 0, 9); step(); in_valid = '0; in_psum = '0;
    setCol(1, 0, 9); step(); in_valid = '0; in_psum = '0;
    step();
    setCol(2, 0, 9); setCol(3, 0, 9); step(); in_valid = '0; in_psum = '0;
    repeat (6) step();
    checkOutput("skew_no_write", wr_cnt - wr0, 0);
    checkOutput("skew_flag", err_skew, 1);
    checkOutput("skew_still_busy", busy, 1);
    pushExpected(1, 1'b0, 10, cyc);
    applyStimulus(1, 10, t0);
    waitDone(dn0);
    repeat (3) step();
    checkOutput("skew_flag_sticky", err_skew, 1);
    checkOutput("skew_recover_writes", wr_cnt - wr0, 1);
    checkOutput("skew_no_overflow", err_overflow, 0);
    sb.delete();

    // Reset mid-pass: abandon after two writes.
    dn0 = done_cnt;
    wr0 = wr_cnt;
    pulseStart(3'd4, 1'b1);
    pushExpected(2, 1'b1, 11, cyc);
    fork
      applyStimulus(4, 11, dummy_t);
    join_none
    for (int k = 0; k < 20 && (wr_cnt - wr0) < 2; k++) @(negedge clk);
    checkOutput("reset_prewrites", wr_cnt - wr0, 2);
    rst_n = 1'b0;
    #1;
    checkOutput("midpass_reset_outputs",
                {acc_wr_en, acc_wr_addr, acc_wr_accum, acc_wr_data, busy, done, err_skew, err_overflow}, 0);
    wait fork;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    checkOutput("reset_no_done", done_cnt - dn0, 0);
    sb.delete();
    dn0 = done_cnt;
    wr0 = wr_cnt;
    pulseStart(3'd1, 1'b0);
    pushExpected(1, 1'b0, 12, cyc);
    applyStimulus(1, 12, t0);
    waitDone(dn0);
    repeat (3) step();
    checkOutput("post_reset_writes", wr_cnt - wr0, 1);
    checkOutput("post_reset_sb_empty", sb.size(), 0);
    sb.delete();

    // Start pulsed during COLLECT is ignored.
    dn0 = done_cnt;
    wr0 = wr_cnt;
    pulseStart(3'd3, 1'b1);
    start = 1'b1;
    num_rows = 3'd1;
    step();
    start = 1'b0;
    pushExpected(3, 1'b1, 13, cyc);
    applyStimulus(3, 13, t0);
    waitDone(dn0);
    repeat (6) step();
    checkOutput("ignored_start_writes", wr_cnt - wr0, 3);
    checkOutput("ignored_start_done", done_cnt - dn0, 1);
    checkOutput("ignored_start_sb_empty", sb.size(), 0);
    checkOutput("ignored_start_no_err", {err_skew, err_overflow}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
